// File: rtl/tt_stream_pkg.sv
// Shared stream types used by the upstream pipeline stage
// and the receive-side buffer.
package tt_stream_pkg;

    localparam int TT_DATA_W = 8;

    typedef logic [TT_DATA_W-1:0] tt_word_t;

endpackage

// File: rtl/tt_sat_counter.sv
// Saturating event counter; a coincident event beats a clear,
// so the count restarts at one rather than zero.
module tt_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            if (clr)
                count <= W'(1);
            else if (count != '1)
                count <= count + W'(1);
        end else if (clr) begin
            count <= '0;
        end
    end

endmodule

// File: rtl/tt_stream_rx_buffer.sv
// Elastic FIFO between an unstallable producer and a valid/ready
// consumer, with first-word fall-through and drop accounting.
module tt_stream_rx_buffer
    import tt_stream_pkg::*;
#(
    parameter int DATA_W = TT_DATA_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  level,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    input  logic              clr_status
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  level_q;
    logic              push;
    logic              pop;
    logic              drop;

    assign level     = level_q;
    assign empty     = (level_q == '0);
    assign full      = (level_q == CNT_W'(DEPTH));
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];

    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    // Storage is deliberately left unreset; reset still blocks the write.
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   level_q <= level_q + CNT_W'(1);
                2'b01:   level_q <= level_q - CNT_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clr_status)
            overflow <= 1'b0;
    end

    tt_sat_counter #(
        .W (DROP_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop),
        .clr   (clr_status),
        .count (drop_count)
    );

endmodule

// File: tb/tb_tt_stream_rx_buffer.sv
// Directed vector table plus hand-written corner sequences
// for the receive-side stream buffer.
module tb_tt_stream_rx_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [3:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [7:0] drop_count;
    logic       clr_status;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tt_stream_rx_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clr_status (clr_status)
    );

    typedef struct {
        logic       r;
        logic       iv;
        logic [7:0] d;
        logic       rdy;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_data;
        logic [3:0] e_level;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
        logic [7:0] e_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic iv, input logic [7:0] d,
                       input logic rdy, input logic clr);
        rst        = r;
        in_valid   = iv;
        in_data    = d;
        out_ready  = rdy;
        clr_status = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic iv, input logic [7:0] d,
                       input logic rdy, input logic clr,
                       input logic ev, input logic [7:0] ed,
                       input logic [3:0] el, input logic ef,
                       input logic ee, input logic eo,
                       input logic [7:0] edr);
        vec_t v;
        v.r = r; v.iv = iv; v.d = d; v.rdy = rdy; v.clr = clr;
        v.e_valid = ev; v.e_data = ed; v.e_level = el;
        v.e_full = ef; v.e_empty = ee; v.e_ovf = eo; v.e_drop = edr;
        vecs.push_back(v);
    endtask

    task automatic chk_state(input string tag, input logic ev,
                             input logic [7:0] ed, input logic [3:0] el,
                             input logic ef, input logic ee,
                             input logic eo, input logic [7:0] edr);
        chk({tag, ".out_valid"}, int'(out_valid), int'(ev));
        chk({tag, ".out_data"}, int'(out_data), int'(ed));
        chk({tag, ".level"}, int'(level), int'(el));
        chk({tag, ".full"}, int'(full), int'(ef));
        chk({tag, ".empty"}, int'(empty), int'(ee));
        chk({tag, ".overflow"}, int'(overflow), int'(eo));
        chk({tag, ".drop_count"}, int'(drop_count), int'(edr));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; clr_status = 1'b0;

        // r iv d rdy clr | valid data level full empty ovf drop
        add(1, 1, 8'hEE, 1, 1, 0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 1, 8'hA5, 0, 0, 1, 8'hA5, 1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 8; i++)
            add(0, 1, 8'(i), 0, 0, 1, 8'h01, 4'(i), i == 8, 0, 0, 0);
        add(0, 1, 8'h09, 0, 0, 1, 8'h01, 8, 1, 0, 1, 1);
        for (int k = 1; k <= 8; k++)
            add(0, 0, 8'h00, 1, 0, k < 8, k < 8 ? 8'(k + 1) : 8'h00,
                4'(8 - k), 0, k == 8, 1, 1);
        add(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 1, 0, 0);
        add(0, 1, 8'h3C, 1, 0, 1, 8'h3C, 1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].r, vecs[i].iv, vecs[i].d, vecs[i].rdy, vecs[i].clr);
            chk_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                      vecs[i].e_level, vecs[i].e_full, vecs[i].e_empty,
                      vecs[i].e_ovf, vecs[i].e_drop);
        end

        // Full FIFO with simultaneous push and pop: no drops, wrap-around.
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 8'(8'h11 + i), 0, 0);
        chk("fill.full", int'(full), 1);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
            chk($sformatf("pass.head%0d", i), int'(out_data), 8'h11 + i);
            @(posedge clk);
            #1;
            chk($sformatf("pass.level%0d", i), int'(level), 8);
            chk($sformatf("pass.drop%0d", i), int'(drop_count), 0);
        end
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b0; out_ready = 1'b1;
            chk($sformatf("drain55.%0d", i), int'(out_data), 8'h55);
            @(posedge clk);
            #1;
        end
        chk("drain55.empty", int'(empty), 1);

        // Saturation of the drop counter, then clear, then clear vs drop.
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 8'(8'h20 + i), 0, 0);
        for (int i = 0; i < 300; i++)
            cyc(0, 1, 8'hFF, 0, 0);
        chk("sat.drop", int'(drop_count), 8'hFF);
        chk("sat.ovf", int'(overflow), 1);
        chk("sat.head", int'(out_data), 8'h20);
        cyc(0, 0, 8'h00, 0, 1);
        chk("clr.drop", int'(drop_count), 0);
        chk("clr.ovf", int'(overflow), 0);
        cyc(0, 1, 8'hFF, 0, 1);
        chk("clrdrop.drop", int'(drop_count), 1);
        chk("clrdrop.ovf", int'(overflow), 1);
        chk("clrdrop.level", int'(level), 8);

        // Reset mid-stream with a word arriving in the reset cycle.
        cyc(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 8'(8'h60 + i), 0, 0);
        chk("mid.level", int'(level), 3);
        cyc(1, 1, 8'h63, 0, 0);
        chk_state("rstmid", 0, 8'h00, 0, 0, 1, 0, 0);
        cyc(0, 1, 8'h71, 0, 0);
        cyc(0, 1, 8'h72, 0, 0);
        chk("post.level", int'(level), 2);
        chk("post.head0", int'(out_data), 8'h71);
        cyc(0, 0, 8'h00, 1, 0);
        chk("post.head1", int'(out_data), 8'h72);
        cyc(0, 0, 8'h00, 1, 0);
        chk("post.empty", int'(empty), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tt_stream_rx_buffer.md
Name: tt_stream_rx_buffer

Overview:
Receive-side elastic buffer for the byte stream produced by our unstallable registered pipeline stages. The upstream stage pushes one word per cycle whenever in_valid is high and cannot be back-pressured. This block absorbs that stream in a small FIFO and re-presents it to a downstream consumer over a valid/ready handshake. It reports occupancy, and it counts and flags any words it must drop because the FIFO is full.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 8, FIFO depth in words; power of two, minimum 2
CNT_W, $clog2(DEPTH+1), width of the level output
DROP_W, 8, width of the saturating drop counter

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  upstream word present this cycle; no ready is returned
in_data  input  DATA_W  upstream word
out_valid  output  1  a word is available to the consumer
out_data  output  DATA_W  head-of-FIFO word
out_ready  input  1  consumer accepts out_data this cycle
level  output  CNT_W  number of words currently stored
full  output  1  level == DEPTH
empty  output  1  level == 0
overflow  output  1  sticky; set when a word is dropped
drop_count  output  DROP_W  saturating count of dropped words
clr_status  input  1  clears overflow and drop_count

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr = 0, rd_ptr = 0, level = 0.
  - empty = 1, full = 0, out_valid = 0.
  - overflow = 0, drop_count = 0.
  - out_data = 0. The storage array is not reset.
  - rst wins over all other inputs in the same cycle. Any in-flight words are discarded; no drop is counted for them.
- First-word fall-through:
  - out_valid = !empty.
  - out_data = mem[rd_ptr] when !empty; otherwise all zeros.
- pop = out_valid && out_ready.
  - On pop, rd_ptr increments.
  - out_ready while empty is ignored.
- push = in_valid && (!full || pop).
  - On push, mem[wr_ptr] <= in_data and wr_ptr increments.
  - A push while full is accepted only when a pop occurs in the same cycle.
- Latency: a word pushed in cycle N has out_valid=1 and appears on out_data in cycle N+1. Zero-bubble throughput of one word per cycle in steady state.
- Level update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
  - full and empty are derived from the registered level.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no special case.
- Drop = in_valid && full && !pop.
  - The word is discarded and storage is untouched.
  - overflow <= 1.
  - drop_count increments, saturating at all ones (no wrap).
- clr_status:
  - Without a drop: overflow <= 0, drop_count <= 0 next cycle.
  - With a drop in the same cycle, the event wins: overflow = 1, drop_count = 1.
- Push into an empty FIFO with out_ready=1: no pop occurs in that cycle (out_valid was 0). The word becomes visible next cycle.
- level, full, empty and out_valid are all consistent in the same cycle; no combinational path from in_* to out_*.

Decomposition:
- Shared package tt_stream_pkg:
  - localparam TT_DATA_W = 8
  - typedef logic [TT_DATA_W-1:0] tt_word_t
  - tt_word_t is reused by the upstream pipeline stage and this buffer.
- One sub-module, tt_sat_counter (parameter W; inputs inc and clr; output count). It implements drop_count with event-over-clear priority.
- FIFO storage and pointer logic stay inline.

Test Plan:
- Reset then idle → out_valid=0, out_data=0x00, level=0, empty=1, full=0, overflow=0, drop_count=0.
- Push 0xA5 at cycle N with out_ready=0 → cycle N+1: out_valid=1, out_data=0xA5, level=1. Assert out_ready one cycle → empty=1, level=0.
- Push 0x01..0x08 on consecutive cycles with out_ready=0 → full=1, level=8. Push 0x09 → dropped: overflow=1, drop_count=1. Then drain 8 words → read order 0x01..0x08, no 0x09.
- Full FIFO, in_valid=1 with 0x55 and out_ready=1 for 8 cycles → level stays 8, no drops. Output sequence is the old contents, then 0x55 words in order. Pointers wrap cleanly.
- Force 300 drops (DROP_W=8) → drop_count saturates at 0xFF. Then clr_status with no drop → overflow=0, drop_count=0. Then clr_status coincident with a drop → overflow=1, drop_count=1.
- Stream 4 words, assert rst mid-stream with in_valid=1 → next cycle level=0, out_valid=0, drop_count=0. Following pushes read back correctly from pointer 0.
